// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
// Drives the selector and data bit of a 1:32 demux. A start request sweeps
// sel0 from a latched first index to a latched last index, wrapping at 31.
// Each index is held for DWELL cycles, and a one-cycle done pulse marks a
// sweep that was not aborted.
module demux_sel_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] first,
  input  logic [4:0] last,
  input  logic       data_in,
  output logic [4:0] sel0,
  output logic       in0,
  output logic       busy,
  output logic       done,
  output logic [5:0] count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Dwell counter runs 0..DWELL-1. Eight bits cover DWELL up to 256.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0] r_state;
  logic [7:0] r_dwell;
  logic [4:0] r_last;
  logic [4:0] r_sel;
  logic       r_in0;
  logic       r_busy;
  logic       r_done;
  logic [5:0] r_count;

  logic       w_dwell_end;
  logic       w_at_last;

  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_at_last   = (r_sel == r_last);

  // Sweep state machine. Every output is registered here.
  // The first index needs no latch of its own: it is loaded straight into sel0.
  // in0 acts as the latch for data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
      r_last  <= '0;
      r_sel   <= '0;
      r_in0   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_in0  <= 1'b0;
          // abort outranks start in IDLE: nothing is latched.
          if (start && !abort) begin
            r_last  <= last;
            r_sel   <= first;
            r_in0   <= data_in;
            r_dwell <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (abort) begin
            // sel0 and count keep their values so the abort point stays visible.
            r_in0   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_dwell_end) begin
            r_count <= r_count + 6'd1;
            if (w_at_last) begin
              r_in0   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_sel   <= r_sel + 5'd1;
              r_dwell <= '0;
            end
          end else begin
            r_dwell <= r_dwell + 8'd1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_in0   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sel0  = r_sel;
  assign in0   = r_in0;
  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer.
// The stimulus pushes the hand-computed summary of each sweep it launches.
// A monitor builds the same summary from the DUT outputs every time busy
// falls, then pops and compares.
module tb_demux_sel_sequencer;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] first = '0;
  logic [4:0] last = '0;
  logic       data_in = 1'b0;
  logic [4:0] sel0;
  logic       in0;
  logic       busy;
  logic       done;
  logic [5:0] count;

  demux_sel_sequencer #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first(first), .last(last), .data_in(data_in),
    .sel0(sel0), .in0(in0), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    logic [4:0] first_sel;
    logic [4:0] end_sel;
    int         segs;
    logic       in_or;
    logic       in_and;
    logic       done_seen;
    logic [5:0] count_v;
    logic       err;
  } rec_t;

  rec_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push(input int cyc, input int f, input int e, input int segs,
                      input bit d, input bit dn, input int cnt);
    rec_t r;
    r.cycles = cyc; r.first_sel = 5'(f); r.end_sel = 5'(e); r.segs = segs;
    r.in_or = d; r.in_and = d; r.done_seen = dn; r.count_v = 6'(cnt); r.err = 1'b0;
    exp_q.push_back(r);
  endtask

  // Monitor: summarise each busy window and check it against the scoreboard.
  initial begin
    bit         prev_busy;
    int         m_cyc, m_segs, m_seglen;
    logic [4:0] m_first, m_cur;
    logic       m_or, m_and, m_err;
    rec_t       e;
    prev_busy = 1'b0;
    m_cyc = 0; m_segs = 0; m_seglen = 0;
    m_first = '0; m_cur = '0; m_or = 1'b0; m_and = 1'b1; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!prev_busy) begin
          m_cyc = 0; m_segs = 1; m_seglen = 0;
          m_first = sel0; m_cur = sel0;
          m_or = 1'b0; m_and = 1'b1; m_err = 1'b0;
        end else if (sel0 != m_cur) begin
          // each finished index must have lasted DWELL cycles and stepped by one
          if (m_seglen != DW || sel0 != 5'(m_cur + 5'd1)) m_err = 1'b1;
          m_segs++;
          m_seglen = 0;
          m_cur = sel0;
        end
        if (done !== 1'b0) m_err = 1'b1;
        m_cyc++;
        m_seglen++;
        m_or = m_or | in0;
        m_and = m_and & in0;
      end else if (prev_busy) begin
        $display("[TB] sweep first=%0d end=%0d cycles=%0d idx=%0d done=%0d count=%0d in0=%0d",
                 m_first, sel0, m_cyc, m_segs, done, count, in0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_sweep: got a sweep, required none");
        end else begin
          e = exp_q.pop_front();
          chk("busy_cycles", m_cyc, e.cycles);
          chk("first_sel", int'(m_first), int'(e.first_sel));
          chk("end_sel", int'(sel0), int'(e.end_sel));
          chk("index_count", m_segs, e.segs);
          chk("in0_or", int'(m_or), int'(e.in_or));
          chk("in0_and", int'(m_and), int'(e.in_and));
          chk("done_pulse", int'(done), int'(e.done_seen));
          chk("count", int'(count), int'(e.count_v));
          chk("dwell_step_err", int'(m_err), int'(e.err));
          chk("in0_after", int'(in0), 0);
        end
      end else begin
        if (done === 1'b1) begin
          tests++; fails++;
          $display("FAIL stray_done: got done=1 outside sweep end, required 0");
        end
        if (in0 === 1'b1 && !rst) begin
          tests++; fails++;
          $display("FAIL in0_idle: got in0=1 while not busy, required 0");
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic do_start(input int f, input int l, input bit d);
    first = 5'(f); last = 5'(l); data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble the inputs to prove they were latched
    first = 5'(f + 7); last = 5'(l + 9); data_in = ~d;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_sel0", int'(sel0), 0);
    chk("rst_in0", int'(in0), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();
    @(negedge clk);

    // single index 25
    push(4, 25, 25, 1, 1'b1, 1'b1, 1);
    do_start(25, 25, 1'b1);
    wait_done(50);
    @(negedge clk);

    // ascending 12..15 with an ignored mid-sweep start
    push(16, 12, 15, 4, 1'b1, 1'b1, 4);
    do_start(12, 15, 1'b1);
    repeat (3) @(negedge clk);
    first = 5'd0; last = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(50);
    @(negedge clk);

    // wrap 30..1
    push(16, 30, 1, 4, 1'b1, 1'b1, 4);
    do_start(30, 1, 1'b1);
    wait_done(50);
    @(negedge clk);

    // full 32-index sweep 5..4
    push(128, 5, 4, 32, 1'b1, 1'b1, 32);
    do_start(5, 4, 1'b1);
    wait_done(300);
    @(negedge clk);

    // abort on the second cycle of index 14
    push(10, 12, 14, 3, 1'b1, 1'b0, 2);
    do_start(12, 15, 1'b1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in0", int'(in0), 0);
    chk("abort_sel0", int'(sel0), 14);
    chk("abort_count", int'(count), 2);
    chk("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);

    // start together with abort in IDLE is refused
    first = 5'd3; last = 5'd3; data_in = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_sel0", int'(sel0), 14);
    chk("start_abort_count", int'(count), 2);

    // data zero sweep 0..3, then a start in the cycle after DONE
    push(16, 0, 3, 4, 1'b0, 1'b1, 4);
    do_start(0, 3, 1'b0);
    wait_done(50);
    @(negedge clk);
    push(4, 7, 7, 1, 1'b1, 1'b1, 1);
    do_start(7, 7, 1'b1);
    chk("b2b_busy_rise", int'(busy), 1);
    chk("b2b_sel0", int'(sel0), 7);
    wait_done(50);
    @(negedge clk);

    // reset from the middle of a sweep
    push(6, 10, 0, 2, 1'b1, 1'b0, 0);
    do_start(10, 20, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
